// File: rtl/cl_seq_expand.sv
// Expands decoded code-length-alphabet symbols (0..18) into one code length per
// symbol, emitted with a valid/ready handshake and an index for table builders.
module cl_seq_expand #(
    parameter int LEN_W     = 4,
    parameter int IDX_W     = 9,
    parameter int MAX_CODES = 320
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [IDX_W-1:0] total_cnt,
    input  logic             sym_valid,
    output logic             sym_ready,
    input  logic [4:0]       sym,
    input  logic [6:0]       sym_extra,
    output logic             len_valid,
    input  logic             len_ready,
    output logic [LEN_W-1:0] len_out,
    output logic [IDX_W-1:0] len_idx,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int CW = IDX_W + 1;
    localparam int SW = ((CW > 8) ? CW : 8) + 1;
    localparam logic [CW-1:0] MAX_C = CW'(MAX_CODES);

    typedef enum logic [2:0] {IDLE, ACCEPT, REPEAT, DONE, ERR} state_t;

    state_t           state_reg,   state_next;
    logic [CW-1:0]    total_reg,   total_next;
    logic [CW-1:0]    idx_reg,     idx_next;
    logic [7:0]       rep_cnt_reg, rep_cnt_next;
    logic [LEN_W-1:0] rep_val_reg, rep_val_next;
    logic [LEN_W-1:0] prev_reg,    prev_next;

    logic [7:0] run_len;
    logic       overrun;
    logic       start_bad;

    always_comb begin
        run_len = 8'd1;
        case (sym)
            5'd16:   run_len = 8'd3  + {6'b0, sym_extra[1:0]};
            5'd17:   run_len = 8'd3  + {5'b0, sym_extra[2:0]};
            5'd18:   run_len = 8'd11 + {1'b0, sym_extra};
            default: run_len = 8'd1;
        endcase
    end

    // Widened sum so a long run near the top of the index range cannot wrap.
    assign overrun   = (SW'(idx_reg) + SW'(run_len)) > SW'(total_reg);
    assign start_bad = (total_cnt == '0) || ({1'b0, total_cnt} > MAX_C);

    always_comb begin
        state_next   = state_reg;
        total_next   = total_reg;
        idx_next     = idx_reg;
        rep_cnt_next = rep_cnt_reg;
        rep_val_next = rep_val_reg;
        prev_next    = prev_reg;

        if (start) begin
            // start wins in every state, aborting any sequence in progress
            idx_next     = '0;
            rep_cnt_next = '0;
            prev_next    = '0;
            if (start_bad) begin
                state_next = ERR;
            end else begin
                total_next = {1'b0, total_cnt};
                state_next = ACCEPT;
            end
        end else begin
            case (state_reg)
                ACCEPT: begin
                    if (sym_valid) begin
                        if (sym > 5'd18 || (sym == 5'd16 && idx_reg == '0) || overrun) begin
                            state_next = ERR;
                        end else begin
                            rep_cnt_next = run_len;
                            state_next   = REPEAT;
                            if (sym < 5'd16) begin
                                rep_val_next = LEN_W'(sym[3:0]);
                                prev_next    = LEN_W'(sym[3:0]);
                            end else if (sym == 5'd16) begin
                                rep_val_next = prev_reg;
                            end else begin
                                rep_val_next = '0;
                                prev_next    = '0;
                            end
                        end
                    end
                end
                REPEAT: begin
                    if (len_ready) begin
                        idx_next     = idx_reg + 1'b1;
                        rep_cnt_next = rep_cnt_reg - 8'd1;
                        if (rep_cnt_reg == 8'd1) begin
                            state_next = (idx_reg + 1'b1 == total_reg) ? DONE : ACCEPT;
                        end
                    end
                end
                DONE:    state_next = IDLE;
                ERR:     state_next = ERR;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            total_reg   <= '0;
            idx_reg     <= '0;
            rep_cnt_reg <= '0;
            rep_val_reg <= '0;
            prev_reg    <= '0;
        end else begin
            state_reg   <= state_next;
            total_reg   <= total_next;
            idx_reg     <= idx_next;
            rep_cnt_reg <= rep_cnt_next;
            rep_val_reg <= rep_val_next;
            prev_reg    <= prev_next;
        end
    end

    assign sym_ready = (state_reg == ACCEPT);
    assign len_valid = (state_reg == REPEAT);
    assign len_out   = rep_val_reg;
    assign len_idx   = idx_reg[IDX_W-1:0];
    assign busy      = (state_reg == ACCEPT) || (state_reg == REPEAT);
    assign done      = (state_reg == DONE);
    assign err       = (state_reg == ERR);

endmodule

// File: tb/tb_cl_seq_expand.sv
// Directed bench for cl_seq_expand: run-length expansion, errors, backpressure,
// abort by restart and asynchronous reset.
module tb_cl_seq_expand;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [8:0] total_cnt;
    logic       sym_valid;
    logic       sym_ready;
    logic [4:0] sym;
    logic [6:0] sym_extra;
    logic       len_valid;
    logic       len_ready;
    logic [3:0] len_out;
    logic [8:0] len_idx;
    logic       busy;
    logic       done;
    logic       err;

    int errors = 0;
    int checks = 0;

    cl_seq_expand #(.LEN_W(4), .IDX_W(9), .MAX_CODES(320)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .total_cnt (total_cnt),
        .sym_valid (sym_valid),
        .sym_ready (sym_ready),
        .sym       (sym),
        .sym_extra (sym_extra),
        .len_valid (len_valid),
        .len_ready (len_ready),
        .len_out   (len_out),
        .len_idx   (len_idx),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_start(input int n);
        start     = 1'b1;
        total_cnt = 9'(n);
        step();
        start     = 1'b0;
    endtask

    task automatic send(input int s, input int e);
        int t;
        sym       = 5'(s);
        sym_extra = 7'(e);
        sym_valid = 1'b1;
        t = 0;
        while (!sym_ready && t < 50) begin
            step();
            t++;
        end
        chk("sym_ready_wait", {31'b0, sym_ready}, 1);
        step();
        sym_valid = 1'b0;
        $display("sym %0d extra %0d sent", s, e);
    endtask

    task automatic collect(input int n, input int val, input int first);
        int t;
        len_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            t = 0;
            while (!len_valid && t < 50) begin
                step();
                t++;
            end
            chk("len_valid", {31'b0, len_valid}, 1);
            chk("len_out", {28'b0, len_out}, val);
            chk("len_idx", {23'b0, len_idx}, first + i);
            step();
        end
        $display("collected %0d lengths of %0d from idx %0d", n, val, first);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; total_cnt = '0;
        sym_valid = 1'b0; sym = '0; sym_extra = '0; len_ready = 1'b0;
        step(); step();
        chk("rst_sym_ready", {31'b0, sym_ready}, 0);
        chk("rst_len_valid", {31'b0, len_valid}, 0);
        chk("rst_len_out", {28'b0, len_out}, 0);
        chk("rst_len_idx", {23'b0, len_idx}, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_done", {31'b0, done}, 0);
        chk("rst_err", {31'b0, err}, 0);
        reset = 1'b1;
        step();

        // literal lengths one per symbol
        do_start(5);
        chk("t1_busy", {31'b0, busy}, 1);
        chk("t1_sym_ready", {31'b0, sym_ready}, 1);
        chk("t1_len_valid", {31'b0, len_valid}, 0);
        send(3, 0);  collect(1, 3, 0);
        send(3, 0);  collect(1, 3, 1);
        send(0, 0);  collect(1, 0, 2);
        send(15, 0); collect(1, 15, 3);
        send(4, 0);  collect(1, 4, 4);
        chk("t1_done", {31'b0, done}, 1);
        chk("t1_busy_end", {31'b0, busy}, 0);
        step();
        chk("t1_done_pulse", {31'b0, done}, 0);

        // repeat previous
        do_start(7);
        send(5, 0);  collect(1, 5, 0);
        send(16, 3); collect(6, 5, 1);
        chk("t2_done", {31'b0, done}, 1);
        step();

        // long zero runs
        do_start(149);
        send(18, 127); collect(138, 0, 0);
        send(17, 7);   collect(10, 0, 138);
        send(2, 0);    collect(1, 2, 148);
        chk("t3_done", {31'b0, done}, 1);
        step();

        // overrun
        do_start(4);
        send(17, 2);
        chk("t4_err", {31'b0, err}, 1);
        chk("t4_len_valid", {31'b0, len_valid}, 0);
        chk("t4_sym_ready", {31'b0, sym_ready}, 0);
        chk("t4_busy", {31'b0, busy}, 0);
        step(); step(); step();
        chk("t4_err_sticky", {31'b0, err}, 1);
        do_start(4);
        chk("t4_err_clear", {31'b0, err}, 0);
        chk("t4_busy_restart", {31'b0, busy}, 1);

        // bad symbols and bad counts
        do_start(3);
        send(16, 1);
        chk("t5_first16_err", {31'b0, err}, 1);
        do_start(3);
        chk("t5_err_clear", {31'b0, err}, 0);
        send(19, 0);
        chk("t5_sym19_err", {31'b0, err}, 1);
        do_start(0);
        chk("t5_zero_from_err", {31'b0, err}, 1);
        do_start(5);
        chk("t5_recover", {31'b0, err}, 0);
        do_start(321);
        chk("t5_321_err", {31'b0, err}, 1);
        do_start(2);
        send(1, 0); collect(1, 1, 0);
        send(1, 0); collect(1, 1, 1);
        chk("t5_done", {31'b0, done}, 1);
        step();
        chk("t5_idle", {31'b0, busy}, 0);
        do_start(0);
        chk("t5_zero_from_idle", {31'b0, err}, 1);

        // restart while busy drops the old run
        do_start(5);
        len_ready = 1'b0;
        send(7, 0);
        chk("ab_len_valid", {31'b0, len_valid}, 1);
        chk("ab_len_out", {28'b0, len_out}, 7);
        do_start(2);
        chk("ab_len_valid_drop", {31'b0, len_valid}, 0);
        chk("ab_busy", {31'b0, busy}, 1);
        chk("ab_done", {31'b0, done}, 0);
        send(1, 0); collect(1, 1, 0);
        send(2, 0); collect(1, 2, 1);
        chk("ab_done_end", {31'b0, done}, 1);
        step();

        // backpressure inside a repeat run
        do_start(5);
        send(4, 0);  collect(1, 4, 0);
        send(16, 1);
        len_ready = 1'b1;
        chk("bp_idx1", {23'b0, len_idx}, 1);
        step();
        len_ready = 1'b0;
        chk("bp_idx2", {23'b0, len_idx}, 2);
        step();
        chk("bp_hold_idx", {23'b0, len_idx}, 2);
        chk("bp_hold_out", {28'b0, len_out}, 4);
        chk("bp_hold_valid", {31'b0, len_valid}, 1);
        step();
        len_ready = 1'b1;
        chk("bp_hold_idx2", {23'b0, len_idx}, 2);
        step();
        chk("bp_idx3", {23'b0, len_idx}, 3);
        step();
        chk("bp_idx4", {23'b0, len_idx}, 4);
        chk("bp_out4", {28'b0, len_out}, 4);
        step();
        chk("bp_done", {31'b0, done}, 1);
        $display("backpressure run complete");
        step();

        // asynchronous reset mid-run
        do_start(5);
        len_ready = 1'b0;
        send(9, 0);
        chk("rm_len_valid", {31'b0, len_valid}, 1);
        chk("rm_len_out", {28'b0, len_out}, 9);
        #2 reset = 1'b0;
        #1;
        chk("rm_len_valid0", {31'b0, len_valid}, 0);
        chk("rm_len_out0", {28'b0, len_out}, 0);
        chk("rm_len_idx0", {23'b0, len_idx}, 0);
        chk("rm_busy0", {31'b0, busy}, 0);
        chk("rm_sym_ready0", {31'b0, sym_ready}, 0);
        chk("rm_err0", {31'b0, err}, 0);
        chk("rm_done0", {31'b0, done}, 0);
        step();
        reset = 1'b1;
        step();
        chk("rm_idle", {31'b0, busy}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cl_seq_expand.md
Name: cl_seq_expand

Overview:
Parametrised successor to the fixed code-length decode stage. It takes the stream of decoded code-length-alphabet symbols (0..18 plus extra bits) and expands run-length codes 16/17/18 into one code length per literal/length and distance symbol. Output uses a valid/ready handshake with an index, so it can feed Huffman table builders of any alphabet size. It sits between the code-length Huffman symbol decoder and the lit/dist table construction.

Parameters:
LEN_W, 4, width of an emitted code length (deflate: 4).
IDX_W, 9, width of output index and total-count input.
MAX_CODES, 320, upper bound accepted for total_cnt; larger values raise err at start.

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; latches total_cnt and begins a new sequence
total_cnt  in  IDX_W  number of lengths to produce (HLIT+257 + HDIST+1)
sym_valid  in  1  input symbol valid
sym_ready  out  1  block can accept a symbol
sym  in  5  code-length symbol 0..18
sym_extra  in  7  extra bits, LSB-aligned (2 bits for 16, 3 for 17, 7 for 18)
len_valid  out  1  output length valid
len_ready  in  1  downstream accepts length
len_out  out  LEN_W  code length
len_idx  out  IDX_W  index of len_out, 0..total_cnt-1
busy  out  1  sequence in progress
done  out  1  high one cycle after the last length is accepted
err  out  1  sticky error until next start or reset

Behaviour:
- Reset (reset=0, async): state IDLE; sym_ready=0, len_valid=0, len_out=0, len_idx=0, busy=0, done=0, err=0, prev length=0, repeat counter=0.
- States: IDLE, ACCEPT, REPEAT, DONE, ERR.
- IDLE: on start, if total_cnt==0 or total_cnt>MAX_CODES go to ERR; otherwise latch the count, clear idx and prev, and go to ACCEPT. busy=1 from the cycle after start.
- ACCEPT: sym_ready=1 and len_valid=0. A symbol is taken on sym_valid&&sym_ready.
  - sym 0..15: load rep_cnt=1, rep_val=sym, prev=sym; go to REPEAT.
  - sym 16: if idx==0 go to ERR. Otherwise rep_val=prev, rep_cnt=3+sym_extra[1:0]; REPEAT.
  - sym 17: rep_val=0, rep_cnt=3+sym_extra[2:0], prev=0; REPEAT.
  - sym 18: rep_val=0, rep_cnt=11+sym_extra[6:0], prev=0; REPEAT.
  - sym>18: go to ERR.
  - Latency: the first length is valid the cycle after the accept.
- REPEAT: sym_ready=0 and len_valid=1, with len_out=rep_val and len_idx=idx.
  - On len_ready: idx++ and rep_cnt--.
  - When rep_cnt reaches 0: if idx==total, go to DONE; otherwise go to ACCEPT.
  - Overrun: a run that would pass total is detected at symbol accept (idx+rep_cnt>total) and goes to ERR. No lengths from that run are emitted.
  - len_out and len_idx hold stable while len_valid && !len_ready.
- DONE: done=1 for one cycle, busy=0, then IDLE.
- ERR: err=1 and busy=0, with sym_ready=0 and len_valid=0. Leave only on start, which clears err and restarts as from IDLE. This includes the start checks: a start carrying an invalid total_cnt re-enters ERR with err held at 1.
- start while busy: abort the current sequence, clear idx, rep_cnt and prev, and restart with the new total_cnt. No done pulse is given for the aborted sequence.
- Reset mid-sequence: immediate return to reset values, and any in-flight output is dropped.
- Widths: rep_cnt is 8 bits (max 138). idx comparison uses IDX_W+1 bits to avoid wrap.

Test Plan:
1. start total_cnt=5; syms 3,3,0,15,4 with len_ready=1 -> len_out 3,3,0,15,4 at idx 0..4, then done pulse and busy=0.
2. total_cnt=7; sym 5 then sym 16 extra=3 (6 copies) -> 7 outputs all =5, idx 0..6, done.
3. total_cnt=149; sym 18 extra=127 (138 zeros), sym 17 extra=7 (10 zeros), sym 2 -> 148 zeros then len 2 at idx 148, done.
4. total_cnt=4; sym 17 extra=2 (5 zeros) -> err=1, no len_valid, sym_ready=0; a new start clears err.
5. start then sym 16 first, and separately sym 19 -> err=1 in both cases. start with total_cnt=0 or 321 -> err=1.
6. Backpressure: len_ready toggled 1,0,0,1 during sym 16 run -> len_out and len_idx held while stalled, no lost or duplicated idx. Reset asserted mid-run -> all outputs 0 in the same cycle.
